// File: rtl/wb_default_responder.sv
// Reserved-register block and default Wishbone terminator: ID/control/status
// registers, a programmable no-acknowledge timeout, fault logging and a maskable IRQ.
module wb_default_responder #(
  parameter int                   ADDRWIDTH       = 10,
  parameter int                   DATAWIDTH       = 32,
  parameter int                   CNTR_WIDTH      = 4,
  parameter int                   DEFAULT_TIMEOUT = 7,
  parameter logic [ADDRWIDTH-1:0] CTRL_ADR        = 10'h07C,
  parameter logic [ADDRWIDTH-1:0] STATUS_ADR      = 10'h07D,
  parameter logic [ADDRWIDTH-1:0] CUST_PROD_ADR   = 10'h07E,
  parameter logic [ADDRWIDTH-1:0] REVISIONS_ADR   = 10'h07F,
  parameter logic [7:0]           CUSTOMER_ID     = 8'h01,
  parameter logic [7:0]           PRODUCT_ID      = 8'h00,
  parameter logic [15:0]          MAJOR_REV       = 16'h0001,
  parameter logic [15:0]          MINOR_REV       = 16'h0000,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE   = 32'hDEFFABAC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_Reserved_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  input  logic                 WBs_ACK_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic                 Timeout_Irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNTR_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic [CNTR_WIDTH-1:0]  timeout_q, timeout_d;
  logic                   irq_en_q, irq_en_d;
  logic                   fault_q, fault_d;
  logic                   fault_we_q, fault_we_d;
  logic [ADDRWIDTH-1:0]   fault_adr_q, fault_adr_d;
  logic [15:0]            fault_cnt_q, fault_cnt_d;
  logic                   irq_q, irq_d;

  logic                   sel;
  logic                   reg_wr;
  logic                   status_clr;
  logic                   timeout_evt;
  logic                   dflt_ack;
  logic [CNTR_WIDTH-1:0]  load_val;
  logic [DATAWIDTH-1:0]   status_rd;
  logic [DATAWIDTH-1:0]   ctrl_rd;
  logic                   unused_dat;

  assign unused_dat = ^WBs_DAT_i[30:CNTR_WIDTH];

  assign sel        = WBs_CYC_Reserved_i & WBs_STB_i;
  assign reg_wr     = sel & WBs_WE_i & ~ack_q;
  assign status_clr = reg_wr & (WBs_ADR_i == STATUS_ADR) & WBs_DAT_i[31];
  // DRAIN is only ever entered from a timeout, so it doubles as the event strobe
  // aligned with the cycle in which the default ACK is on the bus.
  assign timeout_evt = (state_q == ST_DRAIN);
  assign load_val    = (timeout_q == '0) ? CNTR_WIDTH'(1) : timeout_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dflt_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = load_val;
        if (WBs_CYC_i && WBs_STB_i && !WBs_CYC_Reserved_i) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        cnt_d = cnt_q - CNTR_WIDTH'(1);
        if (WBs_ACK_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNTR_WIDTH'(1)) begin
          dflt_ack = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign ack_d = (sel & ~ack_q) | dflt_ack;

  always_comb begin
    timeout_d   = timeout_q;
    irq_en_d    = irq_en_q;
    fault_d     = fault_q;
    fault_we_d  = fault_we_q;
    fault_adr_d = fault_adr_q;
    fault_cnt_d = fault_cnt_q;
    if (reg_wr && (WBs_ADR_i == CTRL_ADR)) begin
      timeout_d = WBs_DAT_i[CNTR_WIDTH-1:0];
      irq_en_d  = WBs_DAT_i[31];
    end
    // A fault arriving in the same cycle as a clear is logged as the first one.
    if (timeout_evt) begin
      if (status_clr) begin
        fault_cnt_d = 16'd1;
        fault_d     = 1'b1;
        fault_adr_d = WBs_ADR_i;
        fault_we_d  = WBs_WE_i;
      end else begin
        if (fault_cnt_q != 16'hFFFF) fault_cnt_d = fault_cnt_q + 16'd1;
        if (!fault_q) begin
          fault_d     = 1'b1;
          fault_adr_d = WBs_ADR_i;
          fault_we_d  = WBs_WE_i;
        end
      end
    end else if (status_clr) begin
      fault_cnt_d = '0;
      fault_d     = 1'b0;
      fault_adr_d = '0;
      fault_we_d  = 1'b0;
    end
    irq_d = fault_q & irq_en_q;
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      timeout_q   <= CNTR_WIDTH'(DEFAULT_TIMEOUT);
      irq_en_q    <= 1'b0;
      fault_q     <= 1'b0;
      fault_we_q  <= 1'b0;
      fault_adr_q <= '0;
      fault_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      timeout_q   <= timeout_d;
      irq_en_q    <= irq_en_d;
      fault_q     <= fault_d;
      fault_we_q  <= fault_we_d;
      fault_adr_q <= fault_adr_d;
      fault_cnt_q <= fault_cnt_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    status_rd                     = '0;
    status_rd[15:0]               = fault_cnt_q;
    status_rd[16 +: ADDRWIDTH]    = fault_adr_q;
    status_rd[30]                 = fault_we_q;
    status_rd[31]                 = fault_q;
    ctrl_rd                       = '0;
    ctrl_rd[CNTR_WIDTH-1:0]       = timeout_q;
    ctrl_rd[31]                   = irq_en_q;
    WBs_DAT_o                     = DEF_REG_VALUE;
    if (WBs_CYC_Reserved_i) begin
      case (WBs_ADR_i)
        CTRL_ADR:      WBs_DAT_o = ctrl_rd;
        STATUS_ADR:    WBs_DAT_o = status_rd;
        CUST_PROD_ADR: WBs_DAT_o = {16'h0000, CUSTOMER_ID, PRODUCT_ID};
        REVISIONS_ADR: WBs_DAT_o = {MAJOR_REV, MINOR_REV};
        default:       WBs_DAT_o = DEF_REG_VALUE;
      endcase
    end
  end

  assign WBs_ACK_o     = ack_q;
  assign Timeout_Irq_o = irq_q;

endmodule

// File: tb/tb_wb_default_responder.sv
// Bench for wb_default_responder: bus driver task, latency/data scoreboard,
// fault-status model and a pass-count summary.
module tb_wb_default_responder;

  localparam logic [31:0] DEF = 32'hDEFFABAC;

  logic        clk;
  logic        rst;
  logic [9:0]  adr_i;
  logic        cyc_res_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] dat_i;
  logic        ack_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq_o;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  wb_default_responder dut (
    .WBs_CLK_i          (clk),
    .WBs_RST_i          (rst),
    .WBs_ADR_i          (adr_i),
    .WBs_CYC_Reserved_i (cyc_res_i),
    .WBs_CYC_i          (cyc_i),
    .WBs_STB_i          (stb_i),
    .WBs_WE_i           (we_i),
    .WBs_DAT_i          (dat_i),
    .WBs_ACK_i          (ack_i),
    .WBs_DAT_o          (dat_o),
    .WBs_ACK_o          (ack_o),
    .Timeout_Irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] status_val(input logic flt, input logic we,
                                             input logic [9:0] adr, input logic [15:0] cnt);
    status_val = {flt, we, 4'b0000, adr, cnt};
  endfunction

  // Drives one access; ip_cyc>0 makes another IP acknowledge in that cycle.
  // exp_lat==0 means no acknowledge from the DUT is allowed at all.
  task automatic wb_xfer(input string tag, input logic res, input logic [9:0] adr,
                         input logic we, input logic [31:0] wdat, input int ip_cyc,
                         input int exp_lat, input logic chk_dat, input logic [31:0] exp_dat,
                         output logic irq_at_ack);
    int          n;
    int          got_lat;
    logic        done;
    logic [31:0] got_dat;
    logic [31:0] e_dat;
    int          e_lat;
    exp_q.push_back(exp_dat);
    lat_q.push_back(exp_lat);
    got_lat = 0; got_dat = '0; irq_at_ack = 1'b0; done = 1'b0; n = 0;
    cyc_i = 1'b1; stb_i = 1'b1; cyc_res_i = res; adr_i = adr; we_i = we; dat_i = wdat; ack_i = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1; n++;
      ack_i = (n == ip_cyc);
      @(negedge clk);
      if (ack_o) begin
        got_lat = n; got_dat = dat_o; irq_at_ack = irq_o; done = 1'b1;
      end else if (n == ip_cyc) begin
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    cyc_i = 1'b0; stb_i = 1'b0; cyc_res_i = 1'b0; we_i = 1'b0; ack_i = 1'b0;
    @(negedge clk);
    if (got_lat != 0) begin
      check({tag, ".ack_single"}, {31'b0, ack_o}, 32'd0);
    end else begin
      for (int k = 0; k < 12 && got_lat == 0; k++) begin
        if (ack_o) got_lat = n + 1 + k;
        @(negedge clk);
      end
    end
    check({tag, ".wait"}, {31'b0, done}, 32'd1);
    e_lat = lat_q.pop_front();
    e_dat = exp_q.pop_front();
    check({tag, ".lat"}, got_lat, e_lat);
    if (chk_dat && got_lat != 0) check({tag, ".dat"}, got_dat, e_dat);
  endtask

  logic        irq_s;
  logic [9:0]  r_adr;
  logic        r_we;
  int          acks;

  initial begin
    rst = 1'b1; adr_i = '0; cyc_res_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    we_i = 1'b0; dat_i = '0; ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.ack", {31'b0, ack_o}, 32'd0);
    check("rst.irq", {31'b0, irq_o}, 32'd0);
    check("rst.dat", dat_o, DEF);

    wb_xfer("rd_cust",  1'b1, 10'h07E, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0100, irq_s);
    wb_xfer("rd_rev",   1'b1, 10'h07F, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0001_0000, irq_s);
    wb_xfer("rd_ctrl",  1'b1, 10'h07C, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0007, irq_s);
    wb_xfer("rd_stat0", 1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0000, irq_s);
    wb_xfer("wr_ro",    1'b1, 10'h07E, 1'b1, 32'hFFFF_FFFF, 0, 1, 1'b0, 32'h0, irq_s);
    wb_xfer("rd_ro",    1'b1, 10'h07E, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0100, irq_s);
    wb_xfer("rd_undec", 1'b1, 10'h07B, 1'b0, 32'h0, 0, 1, 1'b1, DEF, irq_s);

    wb_xfer("to_123",   1'b0, 10'h123, 1'b0, 32'h0, 0, 8, 1'b1, DEF, irq_s);
    wb_xfer("st_123",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h8123_0001, irq_s);
    wb_xfer("ip_c3",    1'b0, 10'h124, 1'b0, 32'h0, 3, 0, 1'b0, 32'h0, irq_s);
    wb_xfer("st_ip3",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h8123_0001, irq_s);
    wb_xfer("ip_c7",    1'b0, 10'h125, 1'b0, 32'h0, 7, 0, 1'b0, 32'h0, irq_s);
    wb_xfer("st_ip7",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h8123_0001, irq_s);
    wb_xfer("wr_st_b0", 1'b1, 10'h07D, 1'b1, 32'h0000_FFFF, 0, 1, 1'b0, 32'h0, irq_s);
    wb_xfer("st_keep",  1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h8123_0001, irq_s);
    wb_xfer("clr1",     1'b1, 10'h07D, 1'b1, 32'h8000_0000, 0, 1, 1'b0, 32'h0, irq_s);
    wb_xfer("st_clr1",  1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0000, irq_s);

    wb_xfer("wr_ctrl2", 1'b1, 10'h07C, 1'b1, 32'h8000_0002, 0, 1, 1'b0, 32'h0, irq_s);
    wb_xfer("rd_ctrl2", 1'b1, 10'h07C, 1'b0, 32'h0, 0, 1, 1'b1, 32'h8000_0002, irq_s);
    wb_xfer("to_200",   1'b0, 10'h200, 1'b1, $urandom, 0, 3, 1'b0, 32'h0, irq_s);
    check("irq_early", {31'b0, irq_o}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'b0, irq_o}, 32'd1);
    wb_xfer("st_200",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, status_val(1'b1, 1'b1, 10'h200, 16'd1), irq_s);
    wb_xfer("to_201",   1'b0, 10'h201, 1'b0, 32'h0, 0, 3, 1'b1, DEF, irq_s);
    wb_xfer("st_201",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, status_val(1'b1, 1'b1, 10'h200, 16'd2), irq_s);
    wb_xfer("clr2",     1'b1, 10'h07D, 1'b1, 32'h8000_0000, 0, 1, 1'b0, 32'h0, irq_s);
    check("irq_hold_at_clr", {31'b0, irq_s}, 32'd1);
    check("irq_drop", {31'b0, irq_o}, 32'd0);
    wb_xfer("st_clr2",  1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0000, irq_s);

    wb_xfer("wr_ctrl0", 1'b1, 10'h07C, 1'b1, 32'h0000_0000, 0, 1, 1'b0, 32'h0, irq_s);
    wb_xfer("rd_ctrl0", 1'b1, 10'h07C, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0000, irq_s);
    wb_xfer("to_300",   1'b0, 10'h300, 1'b0, 32'h0, 0, 2, 1'b1, DEF, irq_s);
    wb_xfer("st_300",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, status_val(1'b1, 1'b0, 10'h300, 16'd1), irq_s);
    force dut.fault_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.fault_cnt_q;
    @(negedge clk);
    wb_xfer("to_301",   1'b0, 10'h301, 1'b0, 32'h0, 0, 2, 1'b1, DEF, irq_s);
    wb_xfer("st_sat",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, status_val(1'b1, 1'b0, 10'h300, 16'hFFFF), irq_s);
    check("irq_masked", {31'b0, irq_o}, 32'd0);
    wb_xfer("wr_ctrl7", 1'b1, 10'h07C, 1'b1, 32'h8000_0007, 0, 1, 1'b0, 32'h0, irq_s);
    check("irq_unmask", {31'b0, irq_o}, 32'd1);

    cyc_i = 1'b1; stb_i = 1'b1; cyc_res_i = 1'b0; adr_i = 10'h155; we_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    acks = 0;
    @(negedge clk);
    check("rstmid.irq", {31'b0, irq_o}, 32'd0);
    check("rstmid.dat", dat_o, DEF);
    for (int k = 0; k < 12; k++) begin
      if (ack_o) acks++;
      @(negedge clk);
    end
    check("rstmid.no_ack", acks, 0);
    wb_xfer("rd_ctrl_r", 1'b1, 10'h07C, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0007, irq_s);
    wb_xfer("rd_stat_r", 1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0000, irq_s);
    r_adr = 10'($urandom_range(10'h100, 10'h3FF));
    r_we  = 1'($urandom_range(0, 1));
    wb_xfer("to_rand",   1'b0, r_adr, r_we, $urandom, 0, 8, ~r_we, DEF, irq_s);
    wb_xfer("st_rand",   1'b1, 10'h07D, 1'b0, 32'h0, 0, 1, 1'b1, status_val(1'b1, r_we, r_adr, 16'd1), irq_s);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
